// File: rtl/dcache_tag_ctrl.sv
// Tag store sequencer for the data cache: valid-clear sweep after reset and flush,
// write-over-lookup arbitration of the single SRAM port, and the one-cycle hit compare.
module dcache_tag_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 256,
  parameter int unsigned TAG_WIDTH  = DATA_WIDTH - 8,
  parameter int unsigned VALID_BIT  = DATA_WIDTH - 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  output logic                         busy_o,
  output logic                         sweep_done_o,
  input  logic                         lkp_req_i,
  output logic                         lkp_gnt_o,
  input  logic [$clog2(NUM_WORDS)-1:0] lkp_index_i,
  input  logic [TAG_WIDTH-1:0]         lkp_tag_i,
  output logic                         lkp_valid_o,
  output logic                         lkp_hit_o,
  input  logic                         wr_req_i,
  output logic                         wr_gnt_o,
  input  logic [$clog2(NUM_WORDS)-1:0] wr_index_i,
  input  logic [TAG_WIDTH-1:0]         wr_tag_i,
  input  logic                         wr_valid_i,
  output logic                         ts_en_o,
  output logic                         ts_we_o,
  output logic [DATA_WIDTH/8-1:0]      ts_be_o,
  output logic [$clog2(NUM_WORDS)-1:0] ts_addr_o,
  output logic [DATA_WIDTH-1:0]        ts_wdata_o,
  input  logic [DATA_WIDTH-1:0]        ts_rdata_i
);

  localparam int unsigned   AW       = $clog2(NUM_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);
  // Bits of a stored word that take part in the hit compare: valid bit plus tag field.
  localparam logic [DATA_WIDTH-1:0] HIT_MASK =
    (DATA_WIDTH'(1) << VALID_BIT) | ((DATA_WIDTH'(1) << TAG_WIDTH) - DATA_WIDTH'(1));

  typedef enum logic [1:0] {
    ST_RESET,
    ST_SWEEP,
    ST_READY
  } state_e;

  state_e                state_q;
  logic [AW-1:0]         cnt_q;
  logic                  pend_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  done_q;
  logic                  ready;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] lkp_word;

  assign ready        = (state_q == ST_READY);
  assign busy_o       = ~ready;
  assign wr_gnt_o     = ready & wr_req_i;
  assign lkp_gnt_o    = ready & lkp_req_i & ~wr_req_i;
  assign sweep_done_o = done_q;
  assign lkp_valid_o  = pend_q;
  assign lkp_hit_o    = pend_q & ((ts_rdata_i & HIT_MASK) == lkp_word);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_word                  = '0;
    wr_word[TAG_WIDTH-1:0]   = wr_tag_i;
    wr_word[VALID_BIT]       = wr_valid_i;
    lkp_word                 = '0;
    lkp_word[TAG_WIDTH-1:0]  = tag_q;
    lkp_word[VALID_BIT]      = 1'b1;
  end

  always_comb begin
    ts_en_o    = 1'b0;
    ts_we_o    = 1'b0;
    ts_be_o    = '0;
    ts_addr_o  = '0;
    ts_wdata_o = '0;
    case (state_q)
      ST_SWEEP: begin
        ts_en_o   = 1'b1;
        ts_we_o   = 1'b1;
        ts_be_o   = '1;
        ts_addr_o = cnt_q;
      end
      ST_READY: begin
        if (wr_req_i) begin
          ts_en_o    = 1'b1;
          ts_we_o    = 1'b1;
          ts_be_o    = '1;
          ts_addr_o  = wr_index_i;
          ts_wdata_o = wr_word;
        end else if (lkp_req_i) begin
          ts_en_o   = 1'b1;
          ts_addr_o = lkp_index_i;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      tag_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      pend_q <= lkp_gnt_o;
      done_q <= 1'b0;
      if (lkp_gnt_o) tag_q <= lkp_tag_i;
      case (state_q)
        ST_RESET: begin
          state_q <= ST_SWEEP;
          cnt_q   <= '0;
        end
        ST_SWEEP: begin
          if (cnt_q == LAST_IDX) begin
            state_q <= ST_READY;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_READY: if (flush_i) state_q <= ST_SWEEP;
        default:  state_q <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Bench for dcache_tag_ctrl: SRAM model, table-driven write/lookup vectors, corner
// sequences for arbitration, flush and reset, and randomized traffic against a tag model.
module tb_dcache_tag_ctrl;
  localparam int DW = 32;
  localparam int NW = 256;
  localparam int TW = 24;
  localparam int AW = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          busy_o, sweep_done_o;
  logic          lkp_req_i = 1'b0, lkp_gnt_o;
  logic [AW-1:0] lkp_index_i = '0;
  logic [TW-1:0] lkp_tag_i = '0;
  logic          lkp_valid_o, lkp_hit_o;
  logic          wr_req_i = 1'b0, wr_gnt_o;
  logic [AW-1:0] wr_index_i = '0;
  logic [TW-1:0] wr_tag_i = '0;
  logic          wr_valid_i = 1'b0;
  logic          ts_en_o, ts_we_o;
  logic [3:0]    ts_be_o;
  logic [AW-1:0] ts_addr_o;
  logic [DW-1:0] ts_wdata_o;
  logic [DW-1:0] ts_rdata_i;
  logic [45:0]   ts_bus;

  assign ts_bus = {ts_en_o, ts_we_o, ts_be_o, ts_addr_o, ts_wdata_o};

  dcache_tag_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .TAG_WIDTH(TW), .VALID_BIT(31)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .busy_o(busy_o),
    .sweep_done_o(sweep_done_o), .lkp_req_i(lkp_req_i), .lkp_gnt_o(lkp_gnt_o),
    .lkp_index_i(lkp_index_i), .lkp_tag_i(lkp_tag_i), .lkp_valid_o(lkp_valid_o),
    .lkp_hit_o(lkp_hit_o), .wr_req_i(wr_req_i), .wr_gnt_o(wr_gnt_o),
    .wr_index_i(wr_index_i), .wr_tag_i(wr_tag_i), .wr_valid_i(wr_valid_i),
    .ts_en_o(ts_en_o), .ts_we_o(ts_we_o), .ts_be_o(ts_be_o), .ts_addr_o(ts_addr_o),
    .ts_wdata_o(ts_wdata_o), .ts_rdata_i(ts_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Tag store SRAM: registered read data from the last read address, byte-enabled writes.
  logic [DW-1:0] mem [NW];
  always @(posedge clk_i) begin
    if (ts_en_o) begin
      if (ts_we_o) begin
        for (int b = 0; b < DW / 8; b++)
          if (ts_be_o[b]) mem[ts_addr_o][8*b +: 8] <= ts_wdata_o[8*b +: 8];
      end else begin
        ts_rdata_i <= mem[ts_addr_o];
      end
    end
  end

  // Reference: what the cache should believe about each entry.
  bit            ref_valid [NW];
  logic [TW-1:0] ref_tag   [NW];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_req_i  = 1'b0;
    lkp_req_i = 1'b0;
    flush_i   = 1'b0;
  endtask

  function automatic logic [DW-1:0] tag_word(input bit v, input logic [TW-1:0] t);
    return {v, 7'd0, t};
  endfunction

  function automatic logic [45:0] ts_exp(input bit en, input bit we, input logic [3:0] be,
                                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {en, we, be, a, d};
  endfunction

  // Checks n sweep cycles from index 0 with every request (and flush) held high.
  task automatic run_sweep(input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      flush_i     = 1'b1;
      wr_req_i    = 1'b1;
      lkp_req_i   = 1'b1;
      wr_index_i  = AW'(i + 3);
      wr_tag_i    = 24'hABCDEF;
      wr_valid_i  = 1'b1;
      lkp_index_i = AW'(i);
      #1;
      check($sformatf("sweep[%0d] port", i), {busy_o, wr_gnt_o, lkp_gnt_o, ts_bus},
            {3'b100, ts_exp(1'b1, 1'b1, 4'hF, AW'(i), '0)});
      tick();
    end
    if (full) begin
      idle();
      #1;
      check("sweep_done pulse", {sweep_done_o, busy_o}, 2'b10);
      for (int i = 0; i < NW; i++) ref_valid[i] = 1'b0;
      tick();
      check("sweep_done one cycle", sweep_done_o, 0);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] idx, input logic [TW-1:0] tag, input bit v);
    wr_req_i = 1'b1; wr_index_i = idx; wr_tag_i = tag; wr_valid_i = v;
    lkp_req_i = 1'b0; flush_i = 1'b0;
    #1;
    check($sformatf("write[%0d] port", idx), {wr_gnt_o, lkp_gnt_o, ts_bus},
          {2'b10, ts_exp(1'b1, 1'b1, 4'hF, idx, tag_word(v, tag))});
    ref_valid[idx] = v;
    ref_tag[idx]   = tag;
    tick();
    wr_req_i = 1'b0;
  endtask

  task automatic do_lookup(input logic [AW-1:0] idx, input logic [TW-1:0] tag, input bit exp_hit);
    lkp_req_i = 1'b1; lkp_index_i = idx; lkp_tag_i = tag;
    wr_req_i = 1'b0; flush_i = 1'b0;
    #1;
    check($sformatf("lookup[%0d] port", idx), {wr_gnt_o, lkp_gnt_o, ts_bus[45:32]},
          {2'b01, 1'b1, 1'b0, 4'h0, idx});
    tick();
    lkp_req_i = 1'b0;
    #1;
    check($sformatf("lookup[%0d] tag %0h result", idx, tag), {lkp_valid_o, lkp_hit_o}, {1'b1, exp_hit});
  endtask

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] idx;
    logic [TW-1:0] tag;
    bit            v;
    bit            exp_hit;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend_v, pend_hit, lk_hold, exp_lg;

    vecs = '{
      '{1'b1, 8'd5,   24'h0001AB, 1'b1, 1'b0},
      '{1'b0, 8'd5,   24'h0001AB, 1'b0, 1'b1},
      '{1'b0, 8'd5,   24'h0001AC, 1'b0, 1'b0},
      '{1'b0, 8'd6,   24'h0001AB, 1'b0, 1'b0},
      '{1'b1, 8'd6,   24'h000000, 1'b1, 1'b0},
      '{1'b0, 8'd6,   24'h000000, 1'b0, 1'b1},
      '{1'b0, 8'd0,   24'h000000, 1'b0, 1'b0},
      '{1'b1, 8'd255, 24'hFFFFFF, 1'b1, 1'b0},
      '{1'b0, 8'd255, 24'hFFFFFF, 1'b0, 1'b1},
      '{1'b0, 8'd255, 24'h7FFFFF, 1'b0, 1'b0},
      '{1'b1, 8'd5,   24'h0001AB, 1'b0, 1'b0},
      '{1'b0, 8'd5,   24'h0001AB, 1'b0, 1'b0},
      '{1'b1, 8'd5,   24'h0001AB, 1'b1, 1'b0},
      '{1'b0, 8'd5,   24'h0001AB, 1'b0, 1'b1}
    };
    // Power-up garbage with valid bits set, so only the sweep can make entries miss.
    for (int i = 0; i < NW; i++) mem[i] <= $urandom | 32'h8000_0000;

    // Reset state with every request asserted.
    wr_req_i = 1'b1; lkp_req_i = 1'b1; flush_i = 1'b1;
    #22;
    check("reset outputs", {busy_o, sweep_done_o, wr_gnt_o, lkp_gnt_o, lkp_valid_o, lkp_hit_o, ts_bus},
          {6'b100000, 46'b0});
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    #1;
    check("reset cycle after release", {busy_o, wr_gnt_o, lkp_gnt_o, ts_en_o}, 4'b1000);
    tick();
    run_sweep(NW, 1'b1);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].idx, vecs[i].tag, vecs[i].v);
      else               do_lookup(vecs[i].idx, vecs[i].tag, vecs[i].exp_hit);
    end

    // Write and lookup in the same cycle: write first, lookup next, result after.
    wr_req_i = 1'b1; wr_index_i = 8'd7; wr_tag_i = 24'h55; wr_valid_i = 1'b1;
    lkp_req_i = 1'b1; lkp_index_i = 8'd7; lkp_tag_i = 24'h55;
    #1;
    check("simultaneous grants", {wr_gnt_o, lkp_gnt_o}, 2'b10);
    ref_valid[7] = 1'b1; ref_tag[7] = 24'h55;
    tick();
    wr_req_i = 1'b0;
    #1;
    check("held lookup granted", {lkp_gnt_o, lkp_valid_o}, 2'b10);
    tick();
    lkp_req_i = 1'b0;
    #1;
    check("held lookup result", {lkp_valid_o, lkp_hit_o}, 2'b11);

    // Lookup in N, invalidate in N+1: N+1 sees pre-write data, N+3 sees the invalidate.
    lkp_req_i = 1'b1; lkp_index_i = 8'd5; lkp_tag_i = 24'h1AB;
    #1;
    check("lookup N grant", lkp_gnt_o, 1);
    tick();
    lkp_req_i = 1'b0;
    wr_req_i = 1'b1; wr_index_i = 8'd5; wr_tag_i = 24'h1AB; wr_valid_i = 1'b0;
    #1;
    check("pre-write result", {wr_gnt_o, lkp_valid_o, lkp_hit_o}, 3'b111);
    ref_valid[5] = 1'b0;
    tick();
    wr_req_i = 1'b0;
    do_lookup(8'd5, 24'h1AB, 1'b0);

    // Flush together with a lookup on a valid entry.
    flush_i = 1'b1; lkp_req_i = 1'b1; lkp_index_i = 8'd7; lkp_tag_i = 24'h55;
    #1;
    check("flush-cycle lookup grant", {lkp_gnt_o, busy_o}, 2'b10);
    tick();
    idle();
    #1;
    check("hit in first sweep cycle", {lkp_valid_o, lkp_hit_o, busy_o}, 3'b111);
    run_sweep(NW, 1'b1);
    do_lookup(8'd7, 24'h55, 1'b0);
    do_lookup(8'd255, 24'hFFFFFF, 1'b0);

    // Reset during a granted lookup drops the result and reruns the sweep.
    do_write(8'd9, 24'h99, 1'b1);
    lkp_req_i = 1'b1; lkp_index_i = 8'd9; lkp_tag_i = 24'h99;
    #1;
    check("lookup before reset", lkp_gnt_o, 1);
    rst_ni = 1'b0;
    #1;
    check("async reset mid-lookup", {busy_o, sweep_done_o, wr_gnt_o, lkp_gnt_o, lkp_valid_o, lkp_hit_o, ts_bus},
          {6'b100000, 46'b0});
    tick();
    lkp_req_i = 1'b0;
    #1;
    check("pending lookup dropped", {lkp_valid_o, lkp_hit_o}, 2'b00);
    tick();
    rst_ni = 1'b1;
    #1;
    check("reset cycle after mid-lookup reset", {busy_o, ts_en_o}, 2'b10);
    tick();
    run_sweep(NW, 1'b1);

    // Reset at sweep index 100.
    flush_i = 1'b1;
    tick();
    run_sweep(100, 1'b0);
    check("sweep index before reset", {ts_en_o, ts_addr_o}, {1'b1, 8'd100});
    rst_ni = 1'b0;
    #1;
    check("async reset mid-sweep", {busy_o, sweep_done_o, wr_gnt_o, lkp_gnt_o, lkp_valid_o, lkp_hit_o, ts_bus},
          {6'b100000, 46'b0});
    tick();
    tick();
    rst_ni = 1'b1;
    idle();
    #1;
    check("reset cycle after mid-sweep reset", {busy_o, ts_en_o}, 2'b10);
    tick();
    run_sweep(NW, 1'b1);

    // Random traffic against the tag model; a stalled lookup holds its payload.
    pend_v = 1'b0; pend_hit = 1'b0; lk_hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      flush_i  = 1'b0;
      wr_req_i = ($urandom_range(0, 2) == 0);
      if (wr_req_i) begin
        wr_index_i = AW'($urandom_range(0, 15));
        wr_tag_i   = TW'($urandom_range(0, 3));
        wr_valid_i = ($urandom_range(0, 3) != 0);
      end
      if (!lk_hold) begin
        lkp_req_i   = ($urandom_range(0, 1) == 1);
        lkp_index_i = AW'($urandom_range(0, 15));
        lkp_tag_i   = TW'($urandom_range(0, 3));
      end
      #1;
      check("rand result", {lkp_valid_o, lkp_hit_o}, {pend_v, pend_v & pend_hit});
      exp_lg = lkp_req_i && !wr_req_i;
      check("rand grants", {wr_gnt_o, lkp_gnt_o}, {wr_req_i, exp_lg});
      if (wr_req_i) begin
        check("rand write port", ts_bus, ts_exp(1'b1, 1'b1, 4'hF, wr_index_i, tag_word(wr_valid_i, wr_tag_i)));
        ref_valid[wr_index_i] = wr_valid_i;
        ref_tag[wr_index_i]   = wr_tag_i;
      end else if (lkp_req_i) begin
        check("rand lookup port", ts_bus[45:32], {1'b1, 1'b0, 4'h0, lkp_index_i});
        pend_hit = ref_valid[lkp_index_i] && (ref_tag[lkp_index_i] == lkp_tag_i);
      end else begin
        check("rand idle port", ts_bus, 46'b0);
      end
      pend_v  = exp_lg;
      lk_hold = lkp_req_i && wr_req_i;
      tick();
    end
    idle();
    #1;
    check("rand final result", {lkp_valid_o, lkp_hit_o}, {pend_v, pend_v & pend_hit});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
